// File: rtl/fpio_host_xfer_if.sv
// Bus and byte-stream bundle between fpio_host_xfer (master) and the fpio
// register port plus local byte producer/consumer (slave).
interface fpio_host_xfer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  read_en;
  logic                  write_en;
  logic [31:0]           write_data;
  logic [31:0]           read_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output addr, read_en, write_en, write_data, tx_ready, rx_data, rx_valid,
    input  read_data, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  addr, read_en, write_en, write_data, tx_ready, rx_data, rx_valid,
    output read_data, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/fpio_host_xfer.sv
// Host-side bus initiator for the fpio register port: pushes a tx byte stream
// into the host-to-ext FIFO and drains the ext-to-host FIFO to an rx stream.
module fpio_host_xfer #(
  parameter int FIFO_BITS     = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int MAX_BURST     = 16,
  parameter int POLL_INTERVAL = 64,
  parameter int POP_SETTLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  fpio_host_xfer_if.master  bus,
  output logic              busy
);

  localparam int CW = FIFO_BITS + 1;
  localparam int GW = $clog2(POLL_INTERVAL + 1);
  localparam int SW = (POP_SETTLE > 1) ? $clog2(POP_SETTLE) : 1;
  localparam logic [CW-1:0] BURST       = CW'(MAX_BURST);
  localparam logic [GW-1:0] GAP_LAST    = GW'(POLL_INTERVAL - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'((POP_SETTLE > 0) ? POP_SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_TX, S_PUSH, S_POLL_RX, S_READ_DATA, S_HOLD, S_POP, S_SETTLE
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            moved_q, moved_d;
  logic            last_tx_q, last_tx_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  read_en_c, write_en_c, tx_ready_c;
  logic [CW-1:0]         avail, clamped;
  logic                  unused_rd;

  assign avail     = bus.read_data[FIFO_BITS:0];
  assign clamped   = (avail > BURST) ? BURST : avail;
  assign unused_rd = ^bus.read_data[31:CW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      moved_q    <= 1'b0;
      last_tx_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      moved_q    <= moved_d;
      last_tx_q  <= last_tx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    moved_d    = moved_q;
    last_tx_d  = last_tx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    addr_c     = '0;
    read_en_c  = 1'b0;
    write_en_c = 1'b0;
    tx_ready_c = 1'b0;
    unique case (state_q)
      // A productive round re-polls straight away; only an empty round waits
      // the full gap before the next poll.
      S_IDLE: begin
        if (moved_q || gap_q == GAP_LAST) begin
          gap_d   = '0;
          moved_d = 1'b0;
          if (bus.tx_valid && !last_tx_q) begin
            state_d   = S_POLL_TX;
            last_tx_d = 1'b1;
          end else begin
            state_d   = S_POLL_RX;
            last_tx_d = 1'b0;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_POLL_TX: begin
        addr_c = ADDR_WIDTH'(1);
        cnt_d  = clamped;
        if (clamped == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PUSH;
          moved_d = 1'b1;
        end
      end
      S_PUSH: begin
        if (bus.tx_valid) begin
          tx_ready_c = 1'b1;
          write_en_c = 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POLL_RX: begin
        addr_c = ADDR_WIDTH'(3);
        cnt_d  = clamped;
        if (clamped == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ_DATA;
          moved_d = 1'b1;
        end
      end
      S_READ_DATA: begin
        addr_c     = ADDR_WIDTH'(2);
        rx_data_d  = bus.read_data[7:0];
        rx_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (bus.rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = S_POP;
        end
      end
      S_POP: begin
        read_en_c = 1'b1;
        cnt_d     = cnt_q - 1'b1;
        settle_d  = '0;
        if (POP_SETTLE == 0) begin
          state_d = (cnt_q > CW'(1)) ? S_READ_DATA : S_IDLE;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = (cnt_q != '0) ? S_READ_DATA : S_IDLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.addr       = addr_c;
  assign bus.read_en    = read_en_c;
  assign bus.write_en   = write_en_c;
  assign bus.write_data = write_en_c ? {24'b0, bus.tx_data} : '0;
  assign bus.tx_ready   = tx_ready_c;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpio_host_xfer.sv
// Scoreboard bench for fpio_host_xfer against a small fpio register-port model.
module tb_fpio_host_xfer;
  localparam int PI = 8;
  localparam int MB = 16;
  localparam int FB = 8;
  localparam int PS = 2;

  logic clk;
  logic rst;
  logic busy;

  fpio_host_xfer_if #(.ADDR_WIDTH(4)) bus ();

  fpio_host_xfer #(
    .FIFO_BITS(FB), .ADDR_WIDTH(4), .MAX_BURST(MB),
    .POLL_INTERVAL(PI), .POP_SETTLE(PS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;

  // fpio model state (written only by the monitor process)
  int         tx_free = 0;
  logic [7:0] rx_mem [128];
  int         rx_rd = 0, rx_wr = 0, rx_cnt = 0;

  // requests from stimulus to the model, and scoreboards
  int         tx_free_req [$];
  logic [7:0] rx_load [$];
  logic [7:0] txq [$];
  logic [7:0] exp_wr [$];
  logic [7:0] exp_rx [$];
  int wr_cyc [$], pop_cyc [$], acc_cyc [$], rd2_cyc [$];
  int poll_addr [$], poll_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Upper bits carry junk so the DUT must use only the avail field.
  always_comb begin
    bus.read_data = '0;
    case (bus.addr)
      4'd1:    bus.read_data = {23'h2AAAAA, 9'(tx_free)};
      4'd2:    bus.read_data = {24'hC3C3C3, rx_mem[rx_rd]};
      4'd3:    bus.read_data = {23'h555555, 9'(rx_cnt)};
      default: bus.read_data = '0;
    endcase
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tx producer: holds the head of txq valid until it is accepted
  initial begin
    logic hs;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs = bus.tx_valid && bus.tx_ready;
      @(posedge clk);
      #1;
      if (hs && txq.size() > 0) void'(txq.pop_front());
      bus.tx_valid = (txq.size() > 0);
      bus.tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
    end
  end

  // monitor: compares DUT activity with the scoreboards and updates the model
  initial begin
    logic [31:0] e;
    logic        accepted = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.read_en || bus.write_en)
          check("strobe_excl", 32'(bus.read_en && bus.write_en), 0);
        if (bus.tx_ready) check("tx_ready_with_write", 32'(bus.write_en), 1);
        if (bus.write_en) begin
          check("wr_addr", 32'(bus.addr), 0);
          check("wr_tx_not_full", 32'(tx_free > 0), 1);
          e = (exp_wr.size() > 0) ? {24'b0, exp_wr.pop_front()} : 32'hFFFF_FFFF;
          check("wr_data", bus.write_data, e);
          wr_cyc.push_back(cyc);
          tx_free--;
        end
        if (bus.read_en) begin
          check("pop_addr", 32'(bus.addr), 0);
          check("pop_nonempty", 32'(rx_cnt > 0), 1);
          check("pop_after_accept", 32'(accepted), 1);
          accepted = 1'b0;
          pop_cyc.push_back(cyc);
          pops++;
          rx_rd = (rx_rd + 1) % 128;
          rx_cnt--;
        end
        if (bus.rx_valid && bus.rx_ready) begin
          e = (exp_rx.size() > 0) ? {24'b0, exp_rx.pop_front()} : 32'hFFFF_FFFF;
          check("rx_data", 32'(bus.rx_data), e);
          check("rx_no_dup", 32'(accepted), 0);
          accepted = 1'b1;
          acc_cyc.push_back(cyc);
        end
        if (busy && !bus.read_en && !bus.write_en && (bus.addr == 4'd1 || bus.addr == 4'd3)) begin
          poll_addr.push_back(int'(bus.addr));
          poll_cyc.push_back(cyc);
        end
        if (busy && bus.addr == 4'd2) rd2_cyc.push_back(cyc);
      end
      while (tx_free_req.size() > 0) tx_free = tx_free_req.pop_front();
      while (rx_load.size() > 0) begin
        rx_mem[rx_wr] = rx_load.pop_front();
        rx_wr = (rx_wr + 1) % 128;
        rx_cnt++;
      end
    end
  end

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while ((exp_wr.size() > 0 || exp_rx.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_wr.size() + exp_rx.size()), 0);
  endtask

  // Ends on the first IDLE cycle after an empty poll, leaving PI idle cycles.
  task automatic wait_quiet();
    int n = 0;
    repeat (3 * PI) tick();
    while (!busy && n < 4 * PI) begin tick(); n++; end
    while (busy && n < 8 * PI) begin tick(); n++; end
    check("quiet", 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0, stable, d;
    logic found;
    rst = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_read_en", 32'(bus.read_en), 0);
    check("rst_write_en", 32'(bus.write_en), 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_tx_ready", 32'(bus.tx_ready), 0);
    check("rst_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_busy", 32'(busy), 0);

    // reset in the middle of a push burst
    tick();
    rst = 1'b0;
    tx_free_req.push_back(10);
    foreach (exp_wr[i]) ;
    for (int i = 0; i < 3; i++) begin
      txq.push_back(8'hD1 + 8'(i));
      exp_wr.push_back(8'hD1 + 8'(i));
    end
    n = 0;
    while (!bus.write_en && n < 100) begin tick(); n++; end
    check("push_seen", 32'(bus.write_en), 1);
    rst = 1'b1;
    #1;
    check("midrst_write_en", 32'(bus.write_en), 0);
    check("midrst_tx_ready", 32'(bus.tx_ready), 0);
    check("midrst_write_data", bus.write_data, 0);
    check("midrst_addr", 32'(bus.addr), 0);
    check("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    n = 0;
    while (!busy && n < 4 * PI) begin tick(); n++; end
    check("first_poll_delay", 32'(n), PI);
    check("first_poll_addr", 32'(bus.addr), 3);
    wait_empty("tx_after_reset", 200);

    // free=3 with four bytes: three back-to-back writes, fourth held
    wait_quiet();
    tx_free_req.push_back(3);
    wr_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      txq.push_back(8'hA1 + 8'(i));
      exp_wr.push_back(8'hA1 + 8'(i));
    end
    n = 0;
    while (exp_wr.size() > 1 && n < 100) begin tick(); n++; end
    check("tx_three_written", 32'(exp_wr.size()), 1);
    d = (wr_cyc.size() >= 3) ? wr_cyc[1] - wr_cyc[0] : -1;
    check("tx_b2b_1", 32'(d), 1);
    d = (wr_cyc.size() >= 3) ? wr_cyc[2] - wr_cyc[1] : -1;
    check("tx_b2b_2", 32'(d), 1);

    // TX full with a byte pending: polls alternate at the poll interval
    poll_addr.delete();
    poll_cyc.delete();
    repeat (5 * (PI + 1)) tick();
    check("full_no_write", 32'(exp_wr.size()), 1);
    check("full_poll_count", 32'(poll_addr.size() >= 4), 1);
    for (int i = 1; i < 4 && i < poll_addr.size(); i++) begin
      check("full_poll_alternate", 32'(poll_addr[i] != poll_addr[i-1]), 1);
      check("full_poll_interval", 32'(poll_cyc[i] - poll_cyc[i-1]), PI + 1);
    end
    tx_free_req.push_back(2);
    wait_empty("tx_refill", 100);
    found = 1'b0;
    if (wr_cyc.size() >= 4)
      foreach (poll_cyc[i])
        if (poll_addr[i] == 1 && poll_cyc[i] > wr_cyc[2] && poll_cyc[i] < wr_cyc[3]) found = 1'b1;
    check("a4_after_poll", 32'(found), 1);

    // RX two bytes, consumer always ready
    wait_quiet();
    pop_cyc.delete();
    acc_cyc.delete();
    rd2_cyc.delete();
    p0 = pops;
    rx_load.push_back(8'h55); exp_rx.push_back(8'h55);
    rx_load.push_back(8'h66); exp_rx.push_back(8'h66);
    wait_empty("rx_two", 100);
    repeat (4) tick();
    check("rx_two_pops", 32'(pops - p0), 2);
    d = (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1;
    check("rx_pop_spacing", 32'(d), 3 + PS);
    d = (pop_cyc.size() >= 1 && acc_cyc.size() >= 1) ? pop_cyc[0] - acc_cyc[0] : -1;
    check("rx_accept_to_pop", 32'(d), 1);
    d = (acc_cyc.size() >= 1 && rd2_cyc.size() >= 1) ? acc_cyc[0] - rd2_cyc[0] : -1;
    check("rx_sample_to_accept", 32'(d), 1);

    // RX byte held while consumer stalls
    wait_quiet();
    bus.rx_ready = 1'b0;
    p0 = pops;
    rx_load.push_back(8'h55); exp_rx.push_back(8'h55);
    n = 0;
    while (!bus.rx_valid && n < 60) begin tick(); n++; end
    check("hold_valid_seen", 32'(bus.rx_valid), 1);
    stable = 0;
    repeat (10) begin
      if (bus.rx_valid && bus.rx_data == 8'h55) stable++;
      tick();
    end
    check("hold_stable", 32'(stable), 10);
    check("hold_no_pop", 32'(pops - p0), 0);
    bus.rx_ready = 1'b1;
    repeat (20) tick();
    check("hold_single_pop", 32'(pops - p0), 1);
    check("hold_delivered", 32'(exp_rx.size()), 0);

    // RX avail above MAX_BURST is clamped per round
    wait_quiet();
    p0 = pops;
    for (int i = 0; i < 40; i++) begin
      rx_load.push_back(8'h10 + 8'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    n = 0;
    while (pops - p0 < MB && n < 200) begin tick(); n++; end
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    check("burst_idle", 32'(busy), 0);
    check("burst_clamp", 32'(pops - p0), MB);
    wait_empty("burst_drain", 600);
    repeat (3) tick();
    check("burst_total", 32'(pops - p0), 40);

    // both sides pending: TX, RX, TX
    wait_quiet();
    poll_addr.delete();
    poll_cyc.delete();
    tx_free_req.push_back(2);
    for (int i = 0; i < 3; i++) begin
      rx_load.push_back(8'h71 + 8'(i));
      exp_rx.push_back(8'h71 + 8'(i));
      txq.push_back(8'hC1 + 8'(i));
      exp_wr.push_back(8'hC1 + 8'(i));
    end
    n = 0;
    while (poll_addr.size() < 3 && n < 200) begin tick(); n++; end
    check("alt_first_tx", 32'((poll_addr.size() > 0) ? poll_addr[0] : 0), 1);
    check("alt_then_rx", 32'((poll_addr.size() > 1) ? poll_addr[1] : 0), 3);
    check("alt_then_tx", 32'((poll_addr.size() > 2) ? poll_addr[2] : 0), 1);
    tx_free_req.push_back(1);
    wait_empty("alt_drain", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
